fft4_sequencer: RTL

Control-and-storage stage wrapped around the combinational radix-2 butterfly of the 4-point FFT datapath.
- Accepts a stream of four complex samples and stores them in bit-reversed order.
- Drives the butterfly's operand ports for two decimation-in-time stages, four butterfly operations in all, and writes the results back in place.
- Streams the four frequency bins out in natural order.

It sits directly upstream (operands) and downstream (results) of the butterfly instance.

---
 rtl/fft4_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fft4_sequencer.sv
// ---------------------------------------------------------------------------
// fft4_sequencer
//
// Control and storage around an external combinational radix-2 butterfly
// that forms a 4-point decimation-in-time FFT. Four complex samples are
// loaded into bit-reversed slots. Four butterflies are then issued, one per
// cycle, with results written back in place. The four bins are then
// streamed out in natural order.
//
// Complex packing: the upper WIDTH/2 bits hold the signed real part and the
// lower WIDTH/2 bits hold the signed imaginary part.
//
// Optional feature: define FFT4_SCALE_EN to halve (arithmetic shift, floor)
// each half of every captured butterfly result. The output is then X[k]/4
// and no stage can overflow. When the macro is undefined, results are
// stored verbatim.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   sequencer accepts a sample (LOAD only)
//   in_data    packed complex input sample
//   out_valid  output bin valid (DRAIN only)
//   out_ready  downstream accepts bin
//   out_data   packed complex output bin X[k]
//   bf_a       butterfly operand A
//   bf_b       butterfly operand B
//   bf_w       butterfly twiddle W
//   bf_out0    butterfly result A + B*W
//   bf_out1    butterfly result A - B*W
//   busy       high in any state other than LOAD
//
// State table:
//   state | meaning
//   LOAD  | accept four samples into bit-reversed slots
//   S1A   | stage 1 butterfly on mem0/mem1, W0
//   S1B   | stage 1 butterfly on mem2/mem3, W0
//   S2A   | stage 2 butterfly on mem0/mem2, W0
//   S2B   | stage 2 butterfly on mem1/mem3, W1 (-j)
//   DRAIN | stream mem0..mem3 out in natural order
// ---------------------------------------------------------------------------
module fft4_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] bf_a,
    output logic [WIDTH-1:0] bf_b,
    output logic [WIDTH-1:0] bf_w,
    input  logic [WIDTH-1:0] bf_out0,
    input  logic [WIDTH-1:0] bf_out1,
    output logic             busy
);

    localparam int H = WIDTH / 2;

    // W0 = 1 + 0j, W1 = 0 - 1j (exact integers, no fractional scaling)
    localparam logic [WIDTH-1:0] W0 = {{(H-1){1'b0}}, 1'b1, {H{1'b0}}};
    localparam logic [WIDTH-1:0] W1 = {{H{1'b0}}, {H{1'b1}}};

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        S1A   = 3'd1,
        S1B   = 3'd2,
        S2A   = 3'd3,
        S2B   = 3'd4,
        DRAIN = 3'd5
    } state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [WIDTH-1:0] mem [4];

    function automatic logic [1:0] bitrev(input logic [1:0] i);
        return {i[0], i[1]};
    endfunction

    // Conditioning applied to every captured butterfly result
    function automatic logic [WIDTH-1:0] capture(input logic [WIDTH-1:0] v);
`ifdef FFT4_SCALE_EN
        // Sign-extending right shift of each half (floor division by 2)
        return {v[WIDTH-1], v[WIDTH-1:H+1], v[H-1], v[H-1:1]};
`else
        return v;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        mem[bitrev(idx)] <= in_data;
                        idx              <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state    <= S1A;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                S1A: begin
                    mem[0] <= capture(bf_out0);
                    mem[1] <= capture(bf_out1);
                    state  <= S1B;
                end
                S1B: begin
                    mem[2] <= capture(bf_out0);
                    mem[3] <= capture(bf_out1);
                    state  <= S2A;
                end
                S2A: begin
                    mem[0] <= capture(bf_out0);
                    mem[2] <= capture(bf_out1);
                    state  <= S2B;
                end
                S2B: begin
                    mem[1]    <= capture(bf_out0);
                    mem[3]    <= capture(bf_out1);
                    state     <= DRAIN;
                    out_valid <= 1'b1;
                end
                DRAIN: begin
                    if (out_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state     <= LOAD;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    idx       <= 2'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Operands are decoded from state and storage so the butterfly result
    // is ready to capture at the edge that ends each compute state.
    always_comb begin
        bf_a = '0;
        bf_b = '0;
        bf_w = '0;
        case (state)
            S1A: begin
                bf_a = mem[0];
                bf_b = mem[1];
                bf_w = W0;
            end
            S1B: begin
                bf_a = mem[2];
                bf_b = mem[3];
                bf_w = W0;
            end
            S2A: begin
                bf_a = mem[0];
                bf_b = mem[2];
                bf_w = W0;
            end
            S2B: begin
                bf_a = mem[1];
                bf_b = mem[3];
                bf_w = W1;
            end
            default: begin
                bf_a = '0;
                bf_b = '0;
                bf_w = '0;
            end
        endcase
    end

    assign out_data = (state == DRAIN) ? mem[idx] : '0;

endmodule
